// File: rtl/ddr_rst_sequencer.sv
// DDR2 reset sequencer: synchronises reset release and PLL lock, then steps the
// controller and user resets out in order around calibration, with a timeout trap.
module ddr_rst_sequencer #(
    parameter int SYNC_STAGES  = 2,
    parameter int PWRUP_CYCLES = 200,
    parameter int STAGE_GAP    = 16,
    parameter int CAL_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       pllLocked,
    input  logic       calDone,
    output logic       rstCtrl,
    output logic       rstUser,
    output logic       calStart,
    output logic       ready,
    output logic       calErr,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RST      = 3'd0,
        S_WAITLOCK = 3'd1,
        S_PWRUP    = 3'd2,
        S_RELCTRL  = 3'd3,
        S_CAL      = 3'd4,
        S_RELUSER  = 3'd5,
        S_READY    = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    localparam logic [15:0] PWRUP_LD = 16'(PWRUP_CYCLES - 1);
    localparam logic [15:0] GAP_LD   = 16'(STAGE_GAP - 1);
    localparam logic [15:0] CAL_LD   = 16'(CAL_TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                   int_rst_n, lock_s;
    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   rst_ctrl_q, rst_ctrl_d;
    logic                   rst_user_q, rst_user_d;
    logic                   cal_start_q, cal_start_d;
    logic                   ready_q, ready_d;
    logic                   cal_err_q, cal_err_d;

    // Assert asynchronously, release after SYNC_STAGES clean edges.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) rst_sync_q <= '0;
        else       rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign int_rst_n   = rst_sync_q[SYNC_STAGES-1];
    assign lock_sync_d = int_rst_n ? {lock_sync_q[SYNC_STAGES-2:0], pllLocked} : '0;
    assign lock_s      = lock_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!int_rst_n) begin
            state_d = S_RST;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RST: state_d = S_WAITLOCK;
                S_WAITLOCK: begin
                    if (lock_s) begin
                        state_d = S_PWRUP;
                        cnt_d   = PWRUP_LD;
                    end
                end
                S_PWRUP, S_RELCTRL, S_CAL, S_RELUSER, S_READY: begin
                    if (!lock_s) begin
                        state_d = S_WAITLOCK;
                        cnt_d   = '0;
                    end else if (state_q == S_CAL && calDone) begin
                        state_d = S_RELUSER;
                        cnt_d   = GAP_LD;
                    end else if (state_q == S_READY) begin
                        state_d = S_READY;
                    end else if (cnt_q == 16'd0) begin
                        case (state_q)
                            S_PWRUP:   begin state_d = S_RELCTRL; cnt_d = GAP_LD; end
                            S_RELCTRL: begin state_d = S_CAL;     cnt_d = CAL_LD; end
                            S_CAL:     state_d = S_ERR;
                            default:   state_d = S_READY;
                        endcase
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_RST;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        rst_ctrl_d  = !(state_d inside {S_RELCTRL, S_CAL, S_RELUSER, S_READY});
        rst_user_d  = (state_d != S_READY);
        ready_d     = (state_d == S_READY);
        cal_start_d = (state_q == S_RELCTRL) && (state_d == S_CAL);
        cal_err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lock_sync_q <= '0;
            state_q     <= S_RST;
            cnt_q       <= '0;
            rst_ctrl_q  <= 1'b1;
            rst_user_q  <= 1'b1;
            cal_start_q <= 1'b0;
            ready_q     <= 1'b0;
            cal_err_q   <= 1'b0;
        end else begin
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_ctrl_q  <= rst_ctrl_d;
            rst_user_q  <= rst_user_d;
            cal_start_q <= cal_start_d;
            ready_q     <= ready_d;
            cal_err_q   <= cal_err_d;
        end
    end

    assign rstCtrl  = rst_ctrl_q;
    assign rstUser  = rst_user_q;
    assign calStart = cal_start_q;
    assign ready    = ready_q;
    assign calErr   = cal_err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_ddr_rst_sequencer.sv
// Bench for ddr_rst_sequencer: default-parameter instance driven through the full
// sequence, lock loss, timeout and reset cases; a second instance with minimal timing.
module tb_ddr_rst_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, pll_locked, cal_done;
    logic       rst_ctrl, rst_user, cal_start, rdy, cal_err;
    logic [2:0] state;

    logic       rst1_n, lock1, cal1;
    logic       rst_ctrl1, rst_user1, cal_start1, rdy1, cal_err1;
    logic [2:0] state1;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [2:0] exp_q[$];
    logic [2:0] exp_state;
    logic [2:0] prev_state;
    logic       mon_en = 1'b0;

    ddr_rst_sequencer dut (
        .clk(clk), .rstN(rst_n), .pllLocked(pll_locked), .calDone(cal_done),
        .rstCtrl(rst_ctrl), .rstUser(rst_user), .calStart(cal_start),
        .ready(rdy), .calErr(cal_err), .state(state)
    );

    ddr_rst_sequencer #(
        .SYNC_STAGES(3), .PWRUP_CYCLES(1), .STAGE_GAP(1), .CAL_TIMEOUT(1)
    ) dut1 (
        .clk(clk), .rstN(rst1_n), .pllLocked(lock1), .calDone(cal1),
        .rstCtrl(rst_ctrl1), .rstUser(rst_user1), .calStart(cal_start1),
        .ready(rdy1), .calErr(cal_err1), .state(state1)
    );

    // Scoreboard: every state change of dut is matched against the expected queue.
    always @(negedge clk) begin
        if (mon_en && state !== prev_state) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_state: got state %0d after %0d, none expected", state, prev_state);
            end else begin
                exp_state = exp_q.pop_front();
                if (state !== exp_state) begin
                    errors++;
                    $display("FAIL sb_state: got state %0d after %0d, expected %0d",
                             state, prev_state, exp_state);
                end
            end
            prev_state = state;
        end
        if (mon_en && cal_start === 1'b1) pulses++;
    end

    task automatic wait_st(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state !== s) begin
            checks++;
            errors++;
            $display("FAIL wait_state: state %0d, expected %0d within %0d cycles", state, s, budget);
        end
    endtask

    task automatic wait_cal_start(input int budget);
        int n;
        n = 0;
        while (cal_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cal_start !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_cal_start: no pulse within %0d cycles", budget);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pll_locked = 1'b0; cal_done = 1'b0;
        rst1_n = 1'b0; lock1 = 1'b1; cal1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({state, rst_ctrl, rst_user, cal_start, rdy, cal_err} !== {3'd0, 5'b11000}) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected %b",
                     {state, rst_ctrl, rst_user, cal_start, rdy, cal_err}, {3'd0, 5'b11000});
        end
        pll_locked = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (state !== 3'd0 || rst_ctrl !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: state %0d rstCtrl %b, expected 0 / 1", state, rst_ctrl);
        end
        prev_state = state;
        mon_en = 1'b1;
    endtask

    task automatic test_normal;
        int n;
        logic hi_ok;
        for (int s = 1; s <= 6; s++) exp_q.push_back(3'(s));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL release_hold: state %0d after 2 edges, expected 0", state);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL release_waitlock: state %0d after 3 edges, expected 1", state);
        end
        wait_st(3'd2, 20);
        n = 0;
        hi_ok = 1'b1;
        while (state === 3'd2 && n < 1000) begin
            if (rst_ctrl !== 1'b1) hi_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 200 || !hi_ok) begin
            errors++;
            $display("FAIL pwrup_len: %0d cycles (rstCtrl high all along=%b), expected 200", n, hi_ok);
        end
        checks++;
        if (rst_ctrl !== 1'b0 || state !== 3'd3) begin
            errors++;
            $display("FAIL relctrl: rstCtrl %b state %0d, expected 0 / 3", rst_ctrl, state);
        end
        n = 0;
        while (cal_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 16 || state !== 3'd4) begin
            errors++;
            $display("FAIL cal_start_gap: %0d cycles in state %0d, expected 16 / 4", n, state);
        end
        @(negedge clk);
        checks++;
        if (cal_start !== 1'b0) begin
            errors++;
            $display("FAIL cal_start_width: calStart %b on 2nd cycle, expected 0", cal_start);
        end
        repeat (49) @(negedge clk);
        cal_done = 1'b1;
        n = 0;
        while (rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 17 || rst_user !== 1'b0 || state !== 3'd6) begin
            errors++;
            $display("FAIL ready_delay: %0d cycles rstUser %b state %0d, expected 17 / 0 / 6",
                     n, rst_user, state);
        end
        cal_done = 1'b0;
        repeat (5) @(negedge clk);
        cal_done = 1'b1;
        repeat (3) @(negedge clk);
        cal_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 3'd6 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL ready_hold: state %0d ready %b, expected 6 / 1", state, rdy);
        end
    endtask

    task automatic test_lock_loss;
        int n;
        exp_q.push_back(3'd1);
        pll_locked = 1'b0;
        n = 0;
        while (state === 3'd6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 3 || {rdy, rst_ctrl, rst_user} !== 3'b011) begin
            errors++;
            $display("FAIL lock_loss: %0d cycles ready/rstCtrl/rstUser %b, expected 3 / 011",
                     n, {rdy, rst_ctrl, rst_user});
        end
        for (int s = 2; s <= 6; s++) exp_q.push_back(3'(s));
        repeat (4) @(negedge clk);
        pll_locked = 1'b1;
        wait_cal_start(500);
        @(negedge clk);
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL rerun_pulses: %0d calStart pulses, expected 2", pulses);
        end
        repeat ($urandom_range(1, 100)) @(negedge clk);
        cal_done = 1'b1;
        n = 0;
        while (rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        cal_done = 1'b0;
        checks++;
        if (n != 17 || state !== 3'd6) begin
            errors++;
            $display("FAIL rerun_ready: %0d cycles state %0d, expected 17 / 6", n, state);
        end
    endtask

    task automatic test_rst_mid_cal;
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd0);
        pll_locked = 1'b0;
        wait_st(3'd1, 20);
        pll_locked = 1'b1;
        wait_cal_start(500);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({state, rst_ctrl, rst_user, cal_start, rdy, cal_err} !== {3'd0, 5'b11000}) begin
            errors++;
            $display("FAIL async_reset: got %b before clk edge, expected %b",
                     {state, rst_ctrl, rst_user, cal_start, rdy, cal_err}, {3'd0, 5'b11000});
        end
        @(negedge clk);
        for (int s = 1; s <= 4; s++) exp_q.push_back(3'(s));
        exp_q.push_back(3'd7);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL rerelease_hold: state %0d after 2 edges, expected 0", state);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL rerelease_waitlock: state %0d after 3 edges, expected 1", state);
        end
    endtask

    task automatic test_timeout;
        int n;
        wait_cal_start(500);
        n = 0;
        while (state === 3'd4 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 4096 || state !== 3'd7) begin
            errors++;
            $display("FAIL timeout_len: %0d cycles then state %0d, expected 4096 / 7", n, state);
        end
        checks++;
        if ({cal_err, rst_ctrl, rst_user, rdy} !== 4'b1110) begin
            errors++;
            $display("FAIL err_outputs: calErr/rstCtrl/rstUser/ready %b, expected 1110",
                     {cal_err, rst_ctrl, rst_user, rdy});
        end
        for (int i = 0; i < 6; i++) begin
            pll_locked = ~pll_locked;
            cal_done   = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) @(negedge clk);
        end
        pll_locked = 1'b1;
        cal_done   = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (state !== 3'd7 || cal_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: state %0d calErr %b, expected 7 / 1", state, cal_err);
        end
    endtask

    task automatic test_tie;
        int n;
        exp_q.push_back(3'd0);
        for (int s = 1; s <= 6; s++) exp_q.push_back(3'(s));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_cal_start(500);
        repeat (4095) @(negedge clk);
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        checks++;
        if (state !== 3'd5 || cal_err !== 1'b0) begin
            errors++;
            $display("FAIL tie_reluser: state %0d calErr %b, expected 5 / 0", state, cal_err);
        end
        n = 1;
        while (rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 17 || cal_err !== 1'b0) begin
            errors++;
            $display("FAIL tie_ready: %0d cycles calErr %b, expected 17 / 0", n, cal_err);
        end
    endtask

    task automatic test_params1;
        logic [4:0] seq_err[3];
        logic [4:0] seq_ok[4];
        logic [4:0] got;
        int n;
        seq_err = '{{3'd3, 2'b00}, {3'd4, 2'b01}, {3'd7, 2'b10}};
        seq_ok  = '{{3'd3, 2'b00}, {3'd4, 2'b01}, {3'd5, 2'b00}, {3'd6, 2'b00}};
        rst1_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state1 !== 3'd0) begin
            errors++;
            $display("FAIL p1_release_hold: state %0d after 3 edges, expected 0", state1);
        end
        @(negedge clk);
        checks++;
        if (state1 !== 3'd1) begin
            errors++;
            $display("FAIL p1_release_waitlock: state %0d after 4 edges, expected 1", state1);
        end
        n = 0;
        while (state1 !== 3'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {state1, rst_ctrl1, cal_start1};
            checks++;
            if (got !== seq_err[i]) begin
                errors++;
                $display("FAIL p1_err_step%0d: state/rstCtrl/calStart %b, expected %b",
                         i, got, seq_err[i]);
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (state1 !== 3'd7 || cal_err1 !== 1'b1) begin
            errors++;
            $display("FAIL p1_err_hold: state %0d calErr %b, expected 7 / 1", state1, cal_err1);
        end
        cal1   = 1'b1;
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        n = 0;
        while (state1 !== 3'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = {state1, rst_ctrl1, cal_start1};
            checks++;
            if (got !== seq_ok[i]) begin
                errors++;
                $display("FAIL p1_ok_step%0d: state/rstCtrl/calStart %b, expected %b",
                         i, got, seq_ok[i]);
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (state1 !== 3'd6 || rdy1 !== 1'b1 || rst_user1 !== 1'b0 || cal_err1 !== 1'b0) begin
            errors++;
            $display("FAIL p1_ready_hold: state %0d ready %b rstUser %b calErr %b, expected 6/1/0/0",
                     state1, rdy1, rst_user1, cal_err1);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_lock_loss();
        test_rst_mid_cal();
        test_timeout();
        test_tie();
        test_params1();
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected states never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
